// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time instruction loader.
package loader_pkg;

  localparam int         ADDR_W_DEF     = 12;
  localparam logic [7:0] SYNC_BYTE_DEF  = 8'hA5;
  localparam int         LEN_W          = 16;
  localparam int         WORD_W         = 32;
  localparam int         BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_WRITE,
    ST_RUN
  } state_e;

  // A frame is usable when it carries at least one word and fits the memory.
  function automatic logic len_ok(input logic [LEN_W-1:0] n, input int addr_w);
    return (n != '0) && (32'(n) <= (32'd1 << addr_w));
  endfunction

endpackage

// File: rtl/instruction_loader_if.sv
// Byte-stream valid/ready channel feeding the loader.
interface instruction_loader_if;

  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  modport master (output in_valid, output in_data, input  in_ready);
  modport slave  (input  in_valid, input  in_data, output in_ready);

endinterface

// File: rtl/instr_mem.sv
// Instruction store: one synchronous write port, one asynchronous read port.
module instr_mem #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  logic [31:0] mem_q [2**ADDR_W];

  // NOTE: the array has no reset, so it maps onto RAM and survives an aborted frame.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/instruction_loader.sv
// Receives a framed byte stream, fills instruction memory, then releases the CPU.
module instruction_loader
  import loader_pkg::*;
#(
  parameter int         ADDR_W    = ADDR_W_DEF,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  instruction_loader_if.slave  in_if,
  input  logic [ADDR_W-1:0]    fetch_addr,
  input  logic                 fetch_sel,
  output logic [31:0]          fetch_data,
  output logic                 cpu_reset,
  output logic                 loading,
  output logic                 load_done,
  output logic                 load_error,
  output logic [ADDR_W:0]      words_loaded
);

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d, len_new;
  logic [ADDR_W-1:0]  idx_q, idx_d;
  logic [ADDR_W:0]    words_q, words_d;
  logic [1:0]         byte_cnt_q, byte_cnt_d;
  logic [WORD_W-1:0]  asm_q, asm_d;
  logic               load_done_q, load_done_d;
  logic               load_error_q, load_error_d;
  logic               mem_we;
  logic               accept;
  logic [31:0]        mem_rdata;

  // Ready depends only on state, so the source never sees a combinational loop.
  assign in_if.in_ready = (state_q != ST_WRITE);
  assign accept         = in_if.in_valid && in_if.in_ready;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    idx_d        = idx_q;
    words_d      = words_q;
    byte_cnt_d   = byte_cnt_q;
    asm_d        = asm_q;
    load_done_d  = load_done_q;
    load_error_d = 1'b0;
    mem_we       = 1'b0;
    len_new      = {in_if.in_data, len_q[7:0]};

    unique case (state_q)
      ST_IDLE: begin
        if (accept && in_if.in_data == SYNC_BYTE) state_d = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        if (accept) begin
          len_d[7:0] = in_if.in_data;
          state_d    = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        if (accept) begin
          len_d = len_new;
          if (!len_ok(len_new, ADDR_W)) begin
            load_error_d = 1'b1;
            load_done_d  = 1'b0;
            state_d      = ST_IDLE;
          end else begin
            idx_d      = '0;
            words_d    = '0;
            byte_cnt_d = '0;
            state_d    = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (accept) begin
          asm_d[8*byte_cnt_q +: 8] = in_if.in_data;
          byte_cnt_d               = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        mem_we  = 1'b1;
        idx_d   = idx_q + 1'b1;
        words_d = words_q + 1'b1;
        if (32'(words_d) == 32'(len_q)) begin
          state_d     = ST_RUN;
          load_done_d = 1'b1;
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_RUN: begin
        if (accept && in_if.in_data == SYNC_BYTE) begin
          state_d     = ST_LEN_LO;
          load_done_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      len_q        <= '0;
      idx_q        <= '0;
      words_q      <= '0;
      byte_cnt_q   <= '0;
      asm_q        <= '0;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      words_q      <= words_d;
      byte_cnt_q   <= byte_cnt_d;
      asm_q        <= asm_d;
      load_done_q  <= load_done_d;
      load_error_q <= load_error_d;
    end
  end

  instr_mem #(.ADDR_W(ADDR_W)) u_mem (
    .clk   (clk),
    .we    (mem_we && !reset),
    .waddr (idx_q),
    .wdata (asm_q),
    .raddr (fetch_addr),
    .rdata (mem_rdata)
  );

  assign cpu_reset    = (state_q != ST_RUN);
  assign loading      = (state_q inside {ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_WRITE});
  assign load_done    = load_done_q;
  assign load_error   = load_error_q;
  assign words_loaded = words_q;
  assign fetch_data   = (fetch_sel && state_q == ST_RUN) ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader: frames, rejects, resets and reloads.
module tb_instruction_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] fetch_addr = '0;
  logic        fetch_sel = 1'b0;
  logic [31:0] fetch_data;
  logic        cpu_reset, loading, load_done, load_error;
  logic [12:0] words_loaded;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  instruction_loader_if in_if ();

  instruction_loader dut (
    .clk          (clk),
    .reset        (reset),
    .in_if        (in_if),
    .fetch_addr   (fetch_addr),
    .fetch_sel    (fetch_sel),
    .fetch_data   (fetch_data),
    .cpu_reset    (cpu_reset),
    .loading      (loading),
    .load_done    (load_done),
    .load_error   (load_error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Presents one byte from a falling edge and returns on the falling edge after acceptance.
  task automatic send_byte(input logic [7:0] b, output int acc_cyc);
    int tries = 0;
    in_if.in_valid = 1'b1;
    in_if.in_data  = b;
    while (in_if.in_ready !== 1'b1 && tries < 20) begin
      @(negedge clk);
      tries++;
    end
    if (tries >= 20) begin
      checks++; errors++;
      $display("FAIL handshake_timeout in_ready=%b required 1", in_if.in_ready);
    end
    @(posedge clk);
    acc_cyc = cyc;
    @(negedge clk);
    in_if.in_valid = 1'b0;
  endtask

  task automatic send_hdr(input logic [15:0] n);
    int c;
    send_byte(8'hA5, c);
    send_byte(n[7:0], c);
    send_byte(n[15:8], c);
  endtask

  task automatic send_word(input logic [31:0] w, output int first_cyc);
    int c;
    logic [31:0] wv;
    wv = w;
    send_byte(wv[7:0], first_cyc);
    send_byte(wv[15:8], c);
    send_byte(wv[23:16], c);
    send_byte(wv[31:24], c);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic fetch_check(input logic [11:0] a, input logic [31:0] exp, input string name);
    fetch_addr = a;
    fetch_sel  = 1'b1;
    #1;
    checks++;
    if (fetch_data !== exp) begin
      errors++;
      $display("FAIL %s fetch_data=%h required %h", name, fetch_data, exp);
    end
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    fetch_sel = 1'b1;
    #1;
    checks++;
    if ({in_if.in_ready, cpu_reset, loading, load_done, load_error} !== 5'b11000) begin
      errors++;
      $display("FAIL reset_flags rdy/cpurst/ld/done/err=%b required 11000",
               {in_if.in_ready, cpu_reset, loading, load_done, load_error});
    end
    checks++;
    if (words_loaded !== 13'd0 || fetch_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_counts words=%0d fetch=%h required 0 0", words_loaded, fetch_data);
    end
    fetch_sel = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_basic_frame();
    int c0, c1;
    send_hdr(16'd2);
    send_word(32'h12345678, c0);
    send_word(32'hDEADBEEF, c1);
    checks++;
    if (c1 - c0 != 5) begin
      errors++;
      $display("FAIL throughput word_gap=%0d cycles required 5", c1 - c0);
    end
    checks++;
    if ({in_if.in_ready, cpu_reset, loading} !== 3'b011 || words_loaded !== 13'd1) begin
      errors++;
      $display("FAIL write_cycle rdy/cpurst/ld=%b words=%0d required 011 1",
               {in_if.in_ready, cpu_reset, loading}, words_loaded);
    end
    @(negedge clk);
    checks++;
    if ({cpu_reset, loading, load_done} !== 3'b001 || words_loaded !== 13'd2) begin
      errors++;
      $display("FAIL basic_run cpurst/ld/done=%b words=%0d required 001 2",
               {cpu_reset, loading, load_done}, words_loaded);
    end
    fetch_check(12'd1, 32'hDEADBEEF, "basic_word1");
    fetch_check(12'd0, 32'h12345678, "basic_word0");
    fetch_sel = 1'b0;
    #1;
    checks++;
    if (fetch_data !== 32'h0) begin
      errors++;
      $display("FAIL fetch_unselected fetch_data=%h required 0", fetch_data);
    end
  endtask

  task automatic test_zero_len();
    send_hdr(16'd0);
    checks++;
    if ({load_error, load_done, cpu_reset, loading} !== 4'b1010) begin
      errors++;
      $display("FAIL zero_len err/done/cpurst/ld=%b required 1010",
               {load_error, load_done, cpu_reset, loading});
    end
    @(negedge clk);
    checks++;
    if (load_error !== 1'b0) begin
      errors++;
      $display("FAIL zero_len_pulse load_error=%b required 0", load_error);
    end
  endtask

  task automatic test_length_limit();
    int c;
    send_hdr(16'd4097);
    checks++;
    if ({load_error, loading} !== 2'b10) begin
      errors++;
      $display("FAIL len_4097 err/ld=%b required 10", {load_error, loading});
    end
    send_hdr(16'd4096);
    checks++;
    if ({load_error, loading} !== 2'b01) begin
      errors++;
      $display("FAIL len_4096_hdr err/ld=%b required 01", {load_error, loading});
    end
    for (int i = 0; i < 4096; i++) send_word(32'hC0DE0000 | 32'(i), c);
    @(negedge clk);
    checks++;
    if ({cpu_reset, load_done} !== 2'b01 || words_loaded !== 13'h1000) begin
      errors++;
      $display("FAIL len_4096_run cpurst/done=%b words=%0d required 01 4096",
               {cpu_reset, load_done}, words_loaded);
    end
    fetch_check(12'hFFF, 32'hC0DE0FFF, "len_4096_last");
    fetch_check(12'h000, 32'hC0DE0000, "len_4096_first");
    fetch_sel = 1'b0;
  endtask

  task automatic test_junk_bytes();
    int c;
    pulse_reset();
    send_byte(8'h11, c);
    send_byte(8'h22, c);
    checks++;
    if ({loading, cpu_reset} !== 2'b01) begin
      errors++;
      $display("FAIL junk_dropped ld/cpurst=%b required 01", {loading, cpu_reset});
    end
    send_hdr(16'd1);
    send_word(32'h11223344, c);
    @(negedge clk);
    checks++;
    if ({cpu_reset, load_done} !== 2'b01 || words_loaded !== 13'd1) begin
      errors++;
      $display("FAIL junk_frame cpurst/done=%b words=%0d required 01 1",
               {cpu_reset, load_done}, words_loaded);
    end
    fetch_check(12'd0, 32'h11223344, "junk_word0");
    fetch_sel = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    int c;
    send_hdr(16'd1);
    send_byte(8'hDD, c);
    send_byte(8'hCC, c);
    reset = 1'b1;
    in_if.in_valid = 1'b1;
    in_if.in_data  = 8'hA5;
    @(negedge clk);
    reset = 1'b0;
    in_if.in_valid = 1'b0;
    checks++;
    if ({in_if.in_ready, cpu_reset, loading, load_done, load_error} !== 5'b11000
        || words_loaded !== 13'd0) begin
      errors++;
      $display("FAIL mid_reset rdy/cpurst/ld/done/err=%b words=%0d required 11000 0",
               {in_if.in_ready, cpu_reset, loading, load_done, load_error}, words_loaded);
    end
    @(negedge clk);
    checks++;
    if (load_error !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_err load_error=%b required 0", load_error);
    end
    send_hdr(16'd1);
    send_word(32'h55667788, c);
    @(negedge clk);
    checks++;
    if ({cpu_reset, load_done, load_error} !== 3'b010) begin
      errors++;
      $display("FAIL mid_reset_reload cpurst/done/err=%b required 010",
               {cpu_reset, load_done, load_error});
    end
    fetch_check(12'd0, 32'h55667788, "mid_reset_word0");
    fetch_check(12'd1, 32'hC0DE0001, "mid_reset_untouched");
    fetch_sel = 1'b0;
  endtask

  task automatic test_reload_from_run();
    int c;
    fetch_addr = 12'd0;
    fetch_sel  = 1'b1;
    send_byte(8'hA5, c);
    checks++;
    if ({cpu_reset, load_done, loading} !== 3'b101 || fetch_data !== 32'h0) begin
      errors++;
      $display("FAIL reload_start cpurst/done/ld=%b fetch=%h required 101 0",
               {cpu_reset, load_done, loading}, fetch_data);
    end
    send_byte(8'h01, c);
    send_byte(8'h00, c);
    send_word(32'h9ABCDEF0, c);
    checks++;
    if (fetch_data !== 32'h0) begin
      errors++;
      $display("FAIL reload_hidden fetch_data=%h required 0", fetch_data);
    end
    @(negedge clk);
    fetch_check(12'd0, 32'h9ABCDEF0, "reload_word0");
    fetch_sel = 1'b0;
  endtask

  initial begin
    in_if.in_valid = 1'b0;
    in_if.in_data  = 8'h00;
    test_reset();
    test_basic_frame();
    test_zero_len();
    test_length_limit();
    test_junk_bytes();
    test_reset_mid_frame();
    test_reload_from_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
